// File: rtl/plotter_pkg.sv
// Shared types and constants for the UART program loader.
package plotter_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 434;
  localparam int unsigned BYTES_PER_WORD   = 4;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {L_LEN_HI, L_LEN_LO, L_DATA, L_DONE} ld_state_e;

endpackage

// File: rtl/uart_dmem_loader_if.sv
// Data-memory write port driven by the loader.
interface uart_dmem_loader_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop rx synchronizer plus mid-bit sampling FSM.
module uart_rx_byte
  import plotter_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_pulse_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] FullCnt = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e       state_q, state_d;
  logic [1:0]      sync_q;
  logic            prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            rx_s, half_tick, full_tick;

  assign rx_s      = sync_q[1];
  assign half_tick = (cnt_q == HalfCnt);
  assign full_tick = (cnt_q == FullCnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RX_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RX_IDLE:  if (prev_q && !rx_s) state_d = RX_START;
      // A start bit that is high again at mid-bit was a glitch.
      RX_START: if (half_tick) state_d = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (full_tick && bit_q == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (full_tick) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    byte_valid_o      = (state_q == RX_STOP) && full_tick && rx_s;
    frame_err_pulse_o = (state_q == RX_STOP) && full_tick && !rx_s;
    byte_data_o       = shift_q;
  end

  always_comb begin
    cnt_d   = cnt_q + CntW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    if (state_q == RX_IDLE) begin
      cnt_d = '0;
    end else if ((state_q == RX_START) ? half_tick : full_tick) begin
      cnt_d = '0;
    end
    if (state_q == RX_START) bit_d = '0;
    if (state_q == RX_DATA && full_tick) begin
      bit_d   = bit_q + 3'd1;
      shift_d = {rx_s, shift_q[7:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      prev_q  <= rx_s;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/uart_dmem_loader.sv
// Receives a length-prefixed program over UART and writes it word-by-word into dmem.
module uart_dmem_loader
  import plotter_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_WORDS    = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_i,
  uart_dmem_loader_if.master  dmem,
  output logic                done_o,
  output logic                frame_err_o,
  output logic [ADDR_W:0]     words_loaded_o
);

  localparam int unsigned LenW = ADDR_W + 1;
  localparam logic [15:0]     MaxW16  = 16'(MAX_WORDS);
  localparam logic [LenW-1:0] MaxWLen = LenW'(MAX_WORDS);

  logic       byte_valid, fe_pulse;
  logic [7:0] byte_data;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk               (clk),
    .reset             (reset),
    .rx_i              (rx_i),
    .byte_valid_o      (byte_valid),
    .byte_data_o       (byte_data),
    .frame_err_pulse_o (fe_pulse)
  );

  ld_state_e         ld_q, ld_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [LenW-1:0]   len_q, len_d, words_q, words_d, hdr_len;
  logic [1:0]        pos_q, pos_d;
  logic [DATA_W-1:0] word_q, word_d, wr_data_q, wr_data_d, next_word;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              wr_en_q, wr_en_d, frame_err_q, frame_err_d;
  logic [15:0]       hdr_n;

  assign hdr_n     = {len_hi_q, byte_data};
  assign hdr_len   = (hdr_n > MaxW16) ? MaxWLen : LenW'(hdr_n);
  assign next_word = {word_q[DATA_W-9:0], byte_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ld_q <= L_LEN_HI;
    else       ld_q <= ld_d;
  end

  always_comb begin
    ld_d = ld_q;
    unique case (ld_q)
      L_LEN_HI: if (byte_valid) ld_d = L_LEN_LO;
      L_LEN_LO: if (byte_valid) ld_d = (hdr_len == '0) ? L_DONE : L_DATA;
      // Leave only once the Nth strobe has been issued so done follows it.
      L_DATA:   if (wr_en_q && (words_q + LenW'(1) == len_q)) ld_d = L_DONE;
      L_DONE:   ld_d = L_DONE;
      default:  ld_d = L_LEN_HI;
    endcase
  end

  always_comb begin
    done_o         = (ld_q == L_DONE);
    frame_err_o    = frame_err_q;
    words_loaded_o = words_q;
    dmem.wr_en     = wr_en_q;
    dmem.wr_addr   = wr_addr_q;
    dmem.wr_data   = wr_data_q;
  end

  always_comb begin
    len_hi_d    = len_hi_q;
    len_d       = len_q;
    pos_d       = pos_q;
    word_d      = word_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    words_d     = wr_en_q ? words_q + LenW'(1) : words_q;
    frame_err_d = frame_err_q | fe_pulse;
    if (byte_valid) begin
      if (ld_q == L_LEN_HI) len_hi_d = byte_data;
      if (ld_q == L_LEN_LO) len_d = hdr_len;
      if (ld_q == L_DATA) begin
        pos_d  = pos_q + 2'd1;
        word_d = next_word;
        if (pos_q == 2'(BYTES_PER_WORD - 1)) begin
          wr_en_d   = 1'b1;
          wr_addr_d = words_q[ADDR_W-1:0];
          wr_data_d = next_word;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_hi_q    <= '0;
      len_q       <= '0;
      pos_q       <= '0;
      word_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      words_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      len_hi_q    <= len_hi_d;
      len_q       <= len_d;
      pos_q       <= pos_d;
      word_q      <= word_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      words_q     <= words_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_uart_dmem_loader.sv
// Self-checking bench for uart_dmem_loader: UART byte driver plus write scoreboard.
module tb_uart_dmem_loader;

  localparam int unsigned CPB  = 16;
  localparam int unsigned AW   = 12;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic done, frame_err;
  logic [AW:0] words_loaded;

  int vectors  = 0;
  int errors   = 0;
  int bv_count = 0;
  bit prev_we  = 1'b0;
  logic [AW+DW-1:0] exp_q[$];

  uart_dmem_loader_if #(.ADDR_W(AW), .DATA_W(DW)) dmem_if ();

  uart_dmem_loader #(
    .CLKS_PER_BIT (CPB),
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .MAX_WORDS    (MAXW)
  ) dut (
    .clk            (clk),
    .reset          (rst),
    .rx_i           (rx),
    .dmem           (dmem_if.master),
    .done_o         (done),
    .frame_err_o    (frame_err),
    .words_loaded_o (words_loaded)
  );

  always #5 clk = ~clk;

  // Write monitor: every strobe must match the oldest expected write.
  initial begin
    logic [AW+DW-1:0] e;
    forever begin
      @(negedge clk);
      if (dut.u_rx.byte_valid_o === 1'b1) bv_count++;
      if (dmem_if.wr_en === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%0h data=%h required=no write",
                   dmem_if.wr_addr, dmem_if.wr_data);
        end else begin
          e = exp_q.pop_front();
          if ({dmem_if.wr_addr, dmem_if.wr_data} !== e) begin
            errors++;
            $display("FAIL write addr/data=%0h/%h required=%0h/%h",
                     dmem_if.wr_addr, dmem_if.wr_data, e[AW+DW-1:DW], e[DW-1:0]);
          end
        end
        vectors++;
        if (prev_we) begin
          errors++;
          $display("FAIL wr_en_consecutive got=1 required=0");
        end
      end
      prev_we = dmem_if.wr_en;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic expect_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_status(input string name, input logic d, input logic fe,
                              input logic [AW:0] wl);
    vectors++;
    if ({done, frame_err, words_loaded} !== {d, fe, wl}) begin
      errors++;
      $display("FAIL %s done/frame_err/words=%b/%b/%0d required=%b/%b/%0d",
               name, done, frame_err, words_loaded, d, fe, wl);
    end
  endtask

  task automatic check_drained(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_writes pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic watch_final_write(input string name);
    int n = 0;
    while (dmem_if.wr_en !== 1'b1 && n < 20 * CPB) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (dmem_if.wr_en !== 1'b1) begin
      errors++;
      $display("FAIL %s_write_timeout wr_en=%b required=1", name, dmem_if.wr_en);
    end else begin
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL %s_done_with_strobe done=%b required=0", name, done);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b1) begin
        errors++;
        $display("FAIL %s_done_after_write done=%b required=1", name, done);
      end
    end
  endtask

  task automatic watch_byte_then_done(input string name);
    int n = 0;
    while (dut.u_rx.byte_valid_o !== 1'b1 && n < 20 * CPB) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (dut.u_rx.byte_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_byte_timeout byte_valid=0 required=1", name);
    end else begin
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL %s_done_early done=%b required=0", name, done);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b1) begin
        errors++;
        $display("FAIL %s_done_after_len done=%b required=1", name, done);
      end
    end
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if ({dmem_if.wr_en, dmem_if.wr_addr, dmem_if.wr_data} !== '0) begin
      errors++;
      $display("FAIL reset_port wr_en/addr/data=%b/%0h/%h required=0/0/0",
               dmem_if.wr_en, dmem_if.wr_addr, dmem_if.wr_data);
    end
    check_status("reset_status", 1'b0, 1'b0, '0);
    apply_reset();
  endtask

  task automatic test_one_word();
    expect_write(0, 32'hDEADBEEF);
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
    fork
      send_byte(8'hEF);
      watch_final_write("one_word");
    join
    repeat (4) @(negedge clk);
    check_status("one_word_status", 1'b1, 1'b0, 13'd1);
    check_drained("one_word");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    expect_write(0, 32'h01020304);
    expect_write(1, 32'hCAFEF00D);
    expect_write(2, 32'h80000001);
    send_byte(8'h00); send_byte(8'h03);
    send_word(32'h01020304);
    send_word(32'hCAFEF00D);
    send_byte(8'h80); send_byte(8'h00); send_byte(8'h00);
    fork
      send_byte(8'h01);
      watch_final_write("b2b");
    join
    repeat (4) @(negedge clk);
    check_status("b2b_status", 1'b1, 1'b0, 13'd3);
    check_drained("b2b");
  endtask

  task automatic test_zero_len();
    apply_reset();
    send_byte(8'h00);
    fork
      send_byte(8'h00);
      watch_byte_then_done("zero_len");
    join
    send_word(32'h11223344);
    repeat (4) @(negedge clk);
    check_status("zero_len_status", 1'b1, 1'b0, '0);
  endtask

  task automatic test_glitch_framing();
    int bv0;
    apply_reset();
    bv0 = bv_count;
    rx = 1'b0;
    repeat (6) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    vectors++;
    if (bv_count != bv0) begin
      errors++;
      $display("FAIL glitch_bytes got=%0d required=0", bv_count - bv0);
    end
    check_status("glitch_status", 1'b0, 1'b0, '0);
    expect_write(0, 32'hDEADBEEF);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'hDE);
    send_byte(8'h55, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check_status("frame_err_set", 1'b0, 1'b1, '0);
    send_byte(8'hAD); send_byte(8'hBE);
    fork
      send_byte(8'hEF);
      watch_final_write("framing");
    join
    repeat (4) @(negedge clk);
    check_status("framing_status", 1'b1, 1'b1, 13'd1);
    check_drained("framing");
  endtask

  task automatic test_reset_mid_word();
    apply_reset();
    expect_write(0, 32'h11223344);
    send_byte(8'h00); send_byte(8'h02);
    send_word(32'h11223344);
    send_byte(8'h55); send_byte(8'h66);
    repeat (2) @(negedge clk);
    check_status("mid_word_before", 1'b0, 1'b0, 13'd1);
    check_drained("mid_word_first");
    #3 rst = 1'b1;
    #1;
    vectors++;
    if ({dmem_if.wr_en, dmem_if.wr_addr, dmem_if.wr_data} !== '0) begin
      errors++;
      $display("FAIL async_reset_port wr_en/addr/data=%b/%0h/%h required=0/0/0",
               dmem_if.wr_en, dmem_if.wr_addr, dmem_if.wr_data);
    end
    check_status("async_reset_status", 1'b0, 1'b0, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    expect_write(0, 32'hAABBCCDD);
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    fork
      send_byte(8'hDD);
      watch_final_write("after_reset");
    join
    repeat (4) @(negedge clk);
    check_status("after_reset_status", 1'b1, 1'b0, 13'd1);
    check_drained("after_reset");
  endtask

  task automatic test_clamp();
    apply_reset();
    for (int i = 0; i < 4; i++) expect_write(AW'(i), 32'hA0B0C000 + 32'(i));
    send_byte(8'h00); send_byte(8'h09);
    for (int i = 0; i < 3; i++) send_word(32'hA0B0C000 + 32'(i));
    send_byte(8'hA0); send_byte(8'hB0); send_byte(8'hC0);
    fork
      send_byte(8'h03);
      watch_final_write("clamp");
    join
    send_word(32'h99999999);
    repeat (4) @(negedge clk);
    check_status("clamp_status", 1'b1, 1'b0, 13'd4);
    check_drained("clamp");
  endtask

  initial begin
    test_reset();
    test_one_word();
    test_back_to_back();
    test_zero_len();
    test_glitch_framing();
    test_reset_mid_word();
    test_clamp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
